// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, flag-index and multiply-FSM definitions
// for the alu_pipe codebase slice.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_ROL  = 4'd8,
    OP_ROR  = 4'd9,
    OP_SLT  = 4'd10,
    OP_SLTU = 4'd11,
    OP_MUL  = 4'd12
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_st_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier (low WIDTH bits), only built with ALU_MUL_EN.
// Ports: clk, reset (sync abort), start/a/b in, ack consumes, done/prod out.
`ifdef ALU_MUL_EN
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  localparam int SHW = $clog2(WIDTH);

  mul_st_e          st;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= MUL_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      unique case (st)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            st     <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH - 1)) st <= MUL_DONE;
        end
        MUL_DONE: begin
          if (ack) st <= MUL_IDLE;
        end
        default: st <= MUL_IDLE;
      endcase
    end
  end

  assign done = (st == MUL_DONE);
  assign prod = acc;

endmodule
`endif

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage elastic ALU (S1 operands, S2 result+flags+err); ALU_MUL_EN adds MUL.
// Ports: clk, reset, in_valid/in_ready/a/b/opcode, out_valid/out_ready/out/flags/err.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;

  logic s2_free;
  logic s1_adv;
  logic mul_busy;

  logic [SHW-1:0]   sh;
  logic [SHW:0]     sh_inv;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic             res_err;
  logic [3:0]       res_flags;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free && !mul_busy;
  assign in_ready = !reset && (!s1_valid || s1_adv);

`ifdef ALU_MUL_EN
  logic             s1_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  // S1 parks the MUL beat until the product is ready to load S2
  assign s1_mul   = s1_valid && (s1_op == OP_MUL);
  assign mul_busy = s1_mul && !mul_done;

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .reset(reset),
    .start(s1_mul && s2_free),
    .ack  (mul_done && s2_free),
    .a    (s1_a),
    .b    (s1_b),
    .done (mul_done),
    .prod (mul_prod)
  );
`else
  assign mul_busy = 1'b0;
`endif

  assign sh     = s1_b[SHW-1:0];
  // sh_inv = WIDTH at sh==0, so the wrapped half shifts out to zero
  assign sh_inv = (SHW+1)'(WIDTH) - {1'b0, sh};
  assign sum    = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff   = s1_a - s1_b;

  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;
    unique case (s1_op)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff;
        res_c = s1_a < s1_b;
        res_v = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND: res = s1_a & s1_b;
      OP_OR:  res = s1_a | s1_b;
      OP_XOR: res = s1_a ^ s1_b;
      OP_SLL: res = s1_a << sh;
      OP_SRL: res = s1_a >> sh;
      OP_SRA: res = $signed(s1_a) >>> sh;
      OP_ROL: res = (s1_a << sh) | (s1_a >> sh_inv);
      OP_ROR: res = (s1_a >> sh) | (s1_a << sh_inv);
      OP_SLT: begin
        res = {{(WIDTH-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
      end
      OP_SLTU: begin
        res = {{(WIDTH-1){1'b0}}, s1_a < s1_b};
      end
`ifdef ALU_MUL_EN
      OP_MUL: res = mul_prod;
`endif
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    res_flags         = '0;
    res_flags[FLAG_N] = !res_err && res[WIDTH-1];
    res_flags[FLAG_Z] = !res_err && (res == '0);
    res_flags[FLAG_C] = res_c;
    res_flags[FLAG_V] = res_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_op    <= opcode;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
      err       <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out       <= res;
      flags     <= res_flags;
      err       <= res_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed + randomized scoreboard bench for alu_pipe (WIDTH=32).
// Honours ALU_MUL_EN for the expected MUL behaviour.
module tb_alu_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [3:0]  flags;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [36:0] q[$];
  logic        chk_rdy;
  logic        stall_prev;
  logic [36:0] stall_val;
  logic [31:0] last_out;
  logic [3:0]  last_flags;
  logic        last_err;

  alu_pipe #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .flags    (flags),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {result, N, Z, C, V, err}
  function automatic logic [36:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    logic [31:0] r;
    logic c, v, e;
    int sh;
    longint sx, sy;
    r = 0; c = 0; v = 0; e = 0;
    sh = int'(y[4:0]);
    sx = $signed(x);
    sy = $signed(y);
    case (op)
      4'd0: begin
        r = x + y;
        c = r < x;
        v = (sx + sy) != longint'($signed(r));
      end
      4'd1: begin
        r = x - y;
        c = x < y;
        v = (sx - sy) != longint'($signed(r));
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x << sh;
      4'd6: r = x >> sh;
      4'd7: r = $signed(x) >>> sh;
      4'd8: r = (sh == 0) ? x : ((x << sh) | (x >> (32 - sh)));
      4'd9: r = (sh == 0) ? x : ((x >> sh) | (x << (32 - sh)));
      4'd10: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd11: r = (x < y) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd12: r = x * y;
`endif
      default: e = 1;
    endcase
    if (e) return {32'd0, 4'd0, 1'b1};
    return {r, r[31], (r == 0), c, v, 1'b0};
  endfunction

  task automatic cycle(input logic iv, input logic [3:0] op,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic ordy, output logic acc);
    logic [36:0] e;
    in_valid  = iv;
    opcode    = op;
    a         = av;
    b         = bv;
    out_ready = ordy;
    #1;
    if (stall_prev) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", {out, flags, err}, stall_val);
    end
    if (chk_rdy)
      check("in_ready", in_ready, !(q.size() == 2 && !ordy));
    if (q.size() == 0)
      check("no_spurious", out_valid, 0);
    if (out_valid && ordy && q.size() != 0) begin
      e = q.pop_front();
      check("out", out, e[36:5]);
      check("flags", flags, e[4:1]);
      check("err", err, e[0]);
      last_out   = out;
      last_flags = flags;
      last_err   = err;
    end
    acc = iv && in_ready;
    if (acc) q.push_back(ref_alu(op, av, bv));
    stall_prev = out_valid && !ordy;
    stall_val  = {out, flags, err};
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input int exp_lat,
                         input string tag);
    logic acc;
    int lat, tries;
    bit mul_chk;
    acc = 0;
    tries = 0;
`ifdef ALU_MUL_EN
    mul_chk = (op == 4'd12);
`else
    mul_chk = 0;
`endif
    while (!acc && tries < 20) begin
      cycle(1, op, av, bv, 1, acc);
      tries++;
    end
    check({tag, "_accept"}, acc, 1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (mul_chk && lat <= 32)
        check({tag, "_busy_in_ready"}, in_ready, 0);
      cycle(0, 0, 0, 0, 1, acc);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    cycle(0, 0, 0, 0, 1, acc);
  endtask

  task automatic drain(input string tag);
    logic acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      cycle(0, 0, 0, 0, 1, acc);
      n++;
    end
    check({tag, "_drained"}, q.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [3:0] op;
    int sent, cyc;
    reset = 1; in_valid = 0; a = 0; b = 0; opcode = 0; out_ready = 0;
    chk_rdy = 0; stall_prev = 0; stall_val = 0;
    last_out = 0; last_flags = 0; last_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out", out, 0);
    check("rst_flags", flags, 0);
    check("rst_err", err, 0);
    reset = 0;
    #1;
    check("rst_in_ready_after", in_ready, 1);

    run_one(4'd0, 32'hFFFF_FFFF, 32'h1, 1, "add");
    check("add_out", last_out, 32'h0);
    check("add_flags", last_flags, 4'b0110);
    check("add_err", last_err, 0);

    run_one(4'd1, 32'h8000_0000, 32'h1, 1, "sub_v");
    check("sub_v_out", last_out, 32'h7FFF_FFFF);
    check("sub_v_flags", last_flags, 4'b0001);

    run_one(4'd1, 32'h1, 32'h2, 1, "sub_b");
    check("sub_b_out", last_out, 32'hFFFF_FFFF);
    check("sub_b_flags", last_flags, 4'b1010);

    run_one(4'd9, 32'h1, 32'h21, 1, "ror");
    check("ror_out", last_out, 32'h8000_0000);
    check("ror_flags", last_flags, 4'b1000);

    run_one(4'd7, 32'h8000_0000, 32'h4, 1, "sra");
    check("sra_out", last_out, 32'hF800_0000);

    run_one(4'd11, 32'h1, 32'hFFFF_FFFF, 1, "sltu");
    check("sltu_out", last_out, 32'h1);

    run_one(4'd8, 32'h8000_0001, 32'h20, 1, "rol0");
    check("rol0_out", last_out, 32'h8000_0001);

    run_one(4'd14, 32'h1234, 32'h5678, 1, "illegal");
    check("illegal_out", last_out, 0);
    check("illegal_flags", last_flags, 0);
    check("illegal_err", last_err, 1);

`ifdef ALU_MUL_EN
    run_one(4'd12, 32'h0001_0003, 32'h5, 34, "mul");
    check("mul_out", last_out, 32'h0005_000F);
    check("mul_err", last_err, 0);
`else
    run_one(4'd12, 32'h0001_0003, 32'h5, 1, "mul");
    check("mul_out", last_out, 0);
    check("mul_err", last_err, 1);
`endif

    // 8 back-to-back beats, out_ready alternating 1,0,...
    chk_rdy = 1;
    sent = 0;
    cyc = 0;
    while (sent < 8 && cyc < 100) begin
      op = 4'($urandom_range(0, 11));
      cycle(1, op, pick(), pick(), (cyc % 2) == 0, acc);
      if (acc) sent++;
      cyc++;
    end
    check("stream_sent", sent, 8);
    drain("stream");

    // random traffic and backpressure
    repeat (400) begin
      op = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
      if (op == 4'd12) op = 4'd13;
`endif
      cycle($urandom_range(0, 3) != 0, op, pick(), pick(),
            $urandom_range(0, 3) != 0, acc);
    end
    drain("random");
    chk_rdy = 0;

    // reset while a MUL is in flight
    acc = 0;
    cyc = 0;
    while (!acc && cyc < 20) begin
      cycle(1, 4'd12, 32'h0001_0003, 32'h5, 1, acc);
      cyc++;
    end
    check("abort_accept", acc, 1);
    repeat (5) cycle(0, 0, 0, 0, 1, acc);
    in_valid = 0;
    reset = 1;
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    reset = 0;
    q.delete();
    stall_prev = 0;
    @(posedge clk);
    #1;
    check("abort_in_ready_after", in_ready, 1);
    repeat (40) cycle(0, 0, 0, 0, 1, acc);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
